// File: rtl/powlib_ipmaxi_rd.sv
// AXI read master: queues word-count read requests, splits them into 4 KB-safe
// INCR bursts and forwards R beats annotated with the byte address of each beat.
module powlib_ipmaxi_rd #(
   parameter int MAX_BURST = 128,
   parameter     ID        = "IPMAXI_RD",
   parameter int EAR       = 0,
   parameter int EDBG      = 0,
   parameter int B_BPD     = 4,
   parameter int B_AW      = 32,
   localparam int B_DW     = 8*B_BPD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [B_AW-1:0] wraddr,
   input  logic [B_DW-1:0] wrdata,
   input  logic            wrvld,
   output logic            wrrdy,
   output logic            wrnf,
   output logic [B_AW-1:0] rdaddr,
   output logic [B_DW-1:0] rddata,
   output logic [1:0]      rdresp,
   output logic            rdvld,
   input  logic            rdrdy,
   output logic [B_AW-1:0] araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [B_DW-1:0] rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   localparam int              LG    = $clog2(B_BPD);
   localparam int              CW    = B_DW + 16;
   localparam logic [B_AW-1:0] AMASK = ~B_AW'(B_BPD - 1);
   // Debug-only parameters have no hardware effect; fold them into a dangling tag.
   localparam logic [7:0]      PTAG  = 8'(EAR) ^ 8'(EDBG) ^ 8'($bits(ID));

   logic unused_ptag_s;
   assign unused_ptag_s = ^PTAG;

   logic [B_AW-1:0] rq_addr_q [8];
   logic [B_DW-1:0] rq_len_q  [8];
   logic [2:0]      rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
   logic [3:0]      rq_cnt_q, rq_cnt_d;
   logic [B_AW-1:0] af_addr_q [4];
   logic [1:0]      af_wp_q, af_wp_d, af_rp_q, af_rp_d;
   logic [2:0]      af_cnt_q, af_cnt_d;
   logic [B_AW-1:0] boff_q, boff_d;

   logic [B_AW-1:0] head_addr_s, next_addr_s;
   logic [B_DW-1:0] head_len_s, next_len_s;
   logic [12:0]     pg_words_s;
   logic [8:0]      lim_s, beats_s;
   logic            rq_empty_s, rq_push_s, rq_pop_s, zero_drop_s, last_burst_s;
   logic            af_full_s, af_empty_s, af_pop_s, ar_hs_s, arvalid_s, beat_s;

   // The head request is consumed in place, so it stays in its slot until its last burst issues.
   assign head_addr_s  = rq_addr_q[rq_rp_q];
   assign head_len_s   = rq_len_q[rq_rp_q];
   assign rq_empty_s   = (rq_cnt_q == 4'd0);
   assign rq_push_s    = wrvld && (rq_cnt_q != 4'd8);
   assign af_full_s    = (af_cnt_q == 3'd4);
   assign af_empty_s   = (af_cnt_q == 3'd0);
   assign zero_drop_s  = !rq_empty_s && (head_len_s == '0);
   assign arvalid_s    = !rq_empty_s && (head_len_s != '0) && !af_full_s;
   assign ar_hs_s      = arvalid_s && arready;
   assign last_burst_s = (CW'(head_len_s) == CW'(beats_s));
   assign rq_pop_s     = zero_drop_s || (ar_hs_s && last_burst_s);
   assign next_addr_s  = head_addr_s + (B_AW'(beats_s) << LG);
   assign next_len_s   = head_len_s - B_DW'(beats_s);
   assign beat_s       = rvalid && rdrdy && !af_empty_s;
   assign af_pop_s     = beat_s && rlast;

   // Burst size: smallest of remaining words, MAX_BURST and words left in the 4 KB page.
   always_comb begin
      pg_words_s = (13'd4096 - {1'b0, head_addr_s[11:0]}) >> LG;
      if ({4'd0, 9'(MAX_BURST)} > pg_words_s) begin
         lim_s = pg_words_s[8:0];
      end else begin
         lim_s = 9'(MAX_BURST);
      end
      if (CW'(head_len_s) < CW'(lim_s)) begin
         beats_s = 9'(head_len_s);
      end else begin
         beats_s = lim_s;
      end
   end

   // Next-state for FIFO pointers, occupancy and the beat offset within the head burst.
   always_comb begin
      rq_wp_d  = rq_wp_q;
      rq_rp_d  = rq_rp_q;
      rq_cnt_d = rq_cnt_q;
      af_wp_d  = af_wp_q;
      af_rp_d  = af_rp_q;
      af_cnt_d = af_cnt_q;
      boff_d   = boff_q;
      if (rq_push_s) begin
         rq_wp_d = rq_wp_q + 3'd1;
      end else begin
         rq_wp_d = rq_wp_q;
      end
      if (rq_pop_s) begin
         rq_rp_d = rq_rp_q + 3'd1;
      end else begin
         rq_rp_d = rq_rp_q;
      end
      case ({rq_push_s, rq_pop_s})
         2'b10:   rq_cnt_d = rq_cnt_q + 4'd1;
         2'b01:   rq_cnt_d = rq_cnt_q - 4'd1;
         default: rq_cnt_d = rq_cnt_q;
      endcase
      if (ar_hs_s) begin
         af_wp_d = af_wp_q + 2'd1;
      end else begin
         af_wp_d = af_wp_q;
      end
      if (af_pop_s) begin
         af_rp_d = af_rp_q + 2'd1;
      end else begin
         af_rp_d = af_rp_q;
      end
      case ({ar_hs_s, af_pop_s})
         2'b10:   af_cnt_d = af_cnt_q + 3'd1;
         2'b01:   af_cnt_d = af_cnt_q - 3'd1;
         default: af_cnt_d = af_cnt_q;
      endcase
      if (beat_s) begin
         if (rlast) begin
            boff_d = '0;
         end else begin
            boff_d = boff_q + B_AW'(B_BPD);
         end
      end else begin
         boff_d = boff_q;
      end
   end

   // Pointer, counter and beat-offset registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rq_wp_q  <= 3'd0;
         rq_rp_q  <= 3'd0;
         rq_cnt_q <= 4'd0;
         af_wp_q  <= 2'd0;
         af_rp_q  <= 2'd0;
         af_cnt_q <= 3'd0;
         boff_q   <= '0;
      end else begin
         rq_wp_q  <= rq_wp_d;
         rq_rp_q  <= rq_rp_d;
         rq_cnt_q <= rq_cnt_d;
         af_wp_q  <= af_wp_d;
         af_rp_q  <= af_rp_d;
         af_cnt_q <= af_cnt_d;
         boff_q   <= boff_d;
      end
   end

   // FIFO storage; push slot and in-place head slot never coincide while both are live.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            rq_addr_q[i] <= '0;
            rq_len_q[i]  <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            af_addr_q[i] <= '0;
         end
      end else begin
         if (rq_push_s) begin
            rq_addr_q[rq_wp_q] <= wraddr & AMASK;
            rq_len_q[rq_wp_q]  <= wrdata;
         end
         if (ar_hs_s && !last_burst_s) begin
            rq_addr_q[rq_rp_q] <= next_addr_s;
            rq_len_q[rq_rp_q]  <= next_len_s;
         end
         if (ar_hs_s) begin
            af_addr_q[af_wp_q] <= head_addr_s;
         end
      end
   end

   assign wrrdy   = (rq_cnt_q != 4'd8);
   assign wrnf    = (rq_cnt_q <= 4'd6);
   assign arvalid = arvalid_s;
   assign araddr  = arvalid_s ? head_addr_s : '0;
   assign arlen   = arvalid_s ? 8'(beats_s - 9'd1) : 8'd0;
   assign arsize  = 3'(LG);
   assign arburst = 2'b01;
   assign rdvld   = rvalid;
   assign rddata  = rdata;
   assign rdresp  = rresp;
   assign rready  = rdrdy;
   assign rdaddr  = af_empty_s ? '0 : af_addr_q[af_rp_q] + boff_q;

endmodule

// File: tb/tb_powlib_ipmaxi_rd.sv
// Randomized bench for powlib_ipmaxi_rd: a request-level burst model predicts every
// AR and every beat address; a small AXI slave returns random R traffic.
module tb_powlib_ipmaxi_rd;
   localparam int MAXB = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wraddr, wrdata, rdaddr, rddata, araddr, rdata;
   logic        wrvld, wrrdy, wrnf, rdvld, rdrdy, arvalid, arready, rlast, rvalid, rready;
   logic [1:0]  rdresp, arburst, rresp;
   logic [7:0]  arlen;
   logic [2:0]  arsize;

   powlib_ipmaxi_rd #(.MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst), .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld),
      .wrrdy(wrrdy), .wrnf(wrnf), .rdaddr(rdaddr), .rddata(rddata), .rdresp(rdresp),
      .rdvld(rdvld), .rdrdy(rdrdy), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] req_a[$], req_c[$], exp_ar_a[$], exp_beat[$];
   logic [7:0]  exp_ar_l[$], sl_len[$];
   int          sl_beat, outstanding, n_ar, n_beats, base;
   int          p_wr, p_ar, p_rv, p_rr;
   bit          r_en, ar_hold, r_hold;
   logic [31:0] h_araddr, h_rdaddr;
   logic [7:0]  h_arlen;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Request-level model: each accepted request becomes a list of bursts and beat addresses.
   function automatic void model_add(input logic [31:0] a, input logic [31:0] c);
      logic [31:0] addr, rem, room, beats;
      addr = (a / 32'd4) * 32'd4;
      rem  = c;
      while (rem != 32'd0) begin
         room  = (32'd4096 - (addr % 32'd4096)) / 32'd4;
         beats = rem;
         if (beats > 32'(MAXB)) beats = 32'(MAXB);
         if (beats > room) beats = room;
         exp_ar_a.push_back(addr);
         exp_ar_l.push_back(8'(beats - 32'd1));
         for (int i = 0; i < int'(beats); i++) exp_beat.push_back(addr + 32'(i) * 32'd4);
         addr = addr + beats * 32'd4;
         rem  = rem - beats;
      end
   endfunction

   task automatic add_req(input logic [31:0] a, input logic [31:0] c);
      req_a.push_back(a);
      req_c.push_back(c);
   endtask

   task automatic cycle();
      @(negedge clk);
      if (req_a.size() != 0 && $urandom_range(99) < p_wr) begin
         wrvld = 1'b1; wraddr = req_a[0]; wrdata = req_c[0];
      end else begin
         wrvld = 1'b0; wraddr = $urandom; wrdata = $urandom;
      end
      arready = ($urandom_range(99) < p_ar);
      if (!r_hold) begin
         if (r_en && sl_len.size() != 0 && $urandom_range(99) < p_rv) begin
            rvalid = 1'b1; rdata = $urandom; rresp = 2'($urandom_range(3));
            rlast  = (sl_beat == int'(sl_len[0]));
         end else begin
            rvalid = 1'b0; rlast = 1'b0; rdata = $urandom; rresp = 2'b00;
         end
      end
      rdrdy = ($urandom_range(99) < p_rr);
      #1;
      check_eq("rdvld", 64'(rdvld), 64'(rvalid));
      check_eq("rready", 64'(rready), 64'(rdrdy));
      if (rvalid) begin
         check_eq("rddata", 64'(rddata), 64'(rdata));
         check_eq("rdresp", 64'(rdresp), 64'(rresp));
      end
      if (r_hold) check_eq("rdaddr_stable", 64'(rdaddr), 64'(h_rdaddr));
      if (ar_hold) begin
         check_eq("ar_hold_vld", 64'(arvalid), 64'd1);
         check_eq("ar_hold_addr", 64'(araddr), 64'(h_araddr));
         check_eq("ar_hold_len", 64'(arlen), 64'(h_arlen));
      end
      if (outstanding >= 4) check_eq("ar_full", 64'(arvalid), 64'd0);
      if (wrvld && wrrdy) model_add(req_a.pop_front(), req_c.pop_front());
      if (arvalid && arready) begin
         n_ar++;
         if (exp_ar_a.size() == 0) begin
            check_eq("ar_unexpected", 64'(arvalid), 64'd0);
         end else begin
            check_eq("araddr", 64'(araddr), 64'(exp_ar_a.pop_front()));
            check_eq("arlen", 64'(arlen), 64'(exp_ar_l.pop_front()));
            check_eq("arsize", 64'(arsize), 64'd2);
            check_eq("arburst", 64'(arburst), 64'd1);
         end
         sl_len.push_back(arlen);
         outstanding++;
      end
      ar_hold = arvalid && !arready; h_araddr = araddr; h_arlen = arlen;
      if (rvalid && rready) begin
         n_beats++;
         if (exp_beat.size() == 0) check_eq("r_unexpected", 64'(rvalid), 64'd0);
         else check_eq("rdaddr", 64'(rdaddr), 64'(exp_beat.pop_front()));
         if (rlast) begin
            if (sl_len.size() != 0) void'(sl_len.pop_front());
            sl_beat = 0;
            outstanding--;
         end else begin
            sl_beat++;
         end
      end
      r_hold = rvalid && !rready; h_rdaddr = rdaddr;
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while ((req_a.size() != 0 || exp_ar_a.size() != 0 || exp_beat.size() != 0 ||
              sl_len.size() != 0) && k < budget) begin
         cycle();
         k++;
      end
      check_eq(tag, 64'(k < budget), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; wrvld = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdrdy = 1'b0;
      req_a.delete(); req_c.delete(); exp_ar_a.delete(); exp_ar_l.delete();
      exp_beat.delete(); sl_len.delete();
      sl_beat = 0; outstanding = 0; ar_hold = 1'b0; r_hold = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; wrvld = 1'b0; wraddr = '0; wrdata = '0; rdrdy = 1'b0; arready = 1'b0;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      sl_beat = 0; outstanding = 0; n_ar = 0; n_beats = 0; ar_hold = 1'b0; r_hold = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      check_eq("rst_arvalid", 64'(arvalid), 64'd0);
      check_eq("rst_araddr", 64'(araddr), 64'd0);
      check_eq("rst_arlen", 64'(arlen), 64'd0);
      check_eq("rst_rdaddr", 64'(rdaddr), 64'd0);
      check_eq("rst_wrrdy", 64'(wrrdy), 64'd1);
      check_eq("rst_wrnf", 64'(wrnf), 64'd1);

      p_wr = 100; p_ar = 100; p_rv = 100; p_rr = 100; r_en = 1'b1;
      base = n_ar; add_req(32'h100, 32'd1); drain("drain_single", 200);
      check_eq("single_ar_count", 64'(n_ar - base), 64'd1);
      base = n_ar; add_req(32'h0, 32'd200); drain("drain_200", 2000);
      check_eq("split200_ar_count", 64'(n_ar - base), 64'd4);
      base = n_ar; add_req(32'hFF8, 32'd4); drain("drain_4k", 200);
      check_eq("cross4k_ar_count", 64'(n_ar - base), 64'd2);

      // Consumer back-pressure in the middle of a burst.
      base = n_beats; add_req(32'h2000, 32'd16);
      for (int k = 0; k < 200 && n_beats < base + 5; k++) cycle();
      p_rr = 0;
      repeat (10) begin
         cycle();
         check_eq("stall_rready", 64'(rready), 64'd0);
      end
      p_rr = 100;
      drain("drain_stall", 400);
      check_eq("stall_beats", 64'(n_beats - base), 64'd16);

      // Outstanding-burst limit with no read data returning.
      r_en = 1'b0; base = n_ar;
      for (int i = 0; i < 5; i++) add_req(32'h4000 + 32'(i) * 32'h40, 32'd1);
      repeat (20) cycle();
      check_eq("limit_ar_count", 64'(n_ar - base), 64'd4);
      check_eq("limit_arvalid", 64'(arvalid), 64'd0);
      r_en = 1'b1;
      drain("drain_limit", 400);
      check_eq("limit_ar_total", 64'(n_ar - base), 64'd5);

      // Random traffic, biased toward page edges, plus a wrap past the top of memory.
      p_wr = 60; p_ar = 60; p_rv = 70; p_rr = 70;
      add_req(32'hFFFF_FFF0, 32'd8);
      for (int i = 0; i < 25; i++) begin
         logic [31:0] a, c;
         if ($urandom_range(1) == 0) a = $urandom;
         else a = ($urandom & 32'hFFFF_F000) | (32'hF80 + ($urandom & 32'h7F));
         c = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(200, 1));
         add_req(a, c);
      end
      drain("drain_random", 40000);

      // Fill the request queue with the AR channel blocked.
      do_reset();
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         wrvld = 1'b1; wraddr = 32'h8000 + 32'(n) * 32'h100; wrdata = 32'd4;
         @(negedge clk);
         wrvld = 1'b0; #1;
         check_eq("fill_wrrdy", 64'(wrrdy), 64'(n < 8));
         check_eq("fill_wrnf", 64'(wrnf), 64'(n < 7));
      end
      check_eq("fill_arvalid", 64'(arvalid), 64'd1);
      check_eq("fill_araddr", 64'(araddr), 64'h8100);
      check_eq("fill_arlen", 64'(arlen), 64'd3);
      @(negedge clk); wrvld = 1'b1; wraddr = 32'h9900; wrdata = 32'd1;
      @(negedge clk); wrvld = 1'b0; #1;
      check_eq("full_reject_wrrdy", 64'(wrrdy), 64'd0);
      @(negedge clk); arready = 1'b1;
      @(negedge clk); arready = 1'b0;
      rvalid = 1'b1; rdrdy = 1'b1; rlast = 1'b0; rdata = 32'hA5A5_0001; #1;
      check_eq("pre_rst_rdaddr0", 64'(rdaddr), 64'h8100);
      @(negedge clk); #1;
      check_eq("pre_rst_rdaddr1", 64'(rdaddr), 64'h8104);
      rst = 1'b0; #1;
      check_eq("midrst_arvalid", 64'(arvalid), 64'd0);
      check_eq("midrst_araddr", 64'(araddr), 64'd0);
      check_eq("midrst_arlen", 64'(arlen), 64'd0);
      check_eq("midrst_rdaddr", 64'(rdaddr), 64'd0);
      check_eq("midrst_wrrdy", 64'(wrrdy), 64'd1);
      check_eq("midrst_wrnf", 64'(wrnf), 64'd1);
      @(negedge clk); rst = 1'b1; rlast = 1'b1; #1;
      check_eq("post_rst_rdaddr", 64'(rdaddr), 64'd0);
      @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
      check_eq("post_rst_rdaddr2", 64'(rdaddr), 64'd0);
      check_eq("post_rst_arvalid", 64'(arvalid), 64'd0);

      // Normal operation resumes after reset.
      do_reset();
      p_wr = 100; p_ar = 80; p_rv = 80; p_rr = 80; r_en = 1'b1;
      add_req(32'h0000_0083, 32'd3);
      drain("drain_recover", 400);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
